// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types for the RV32I five-stage core: ALU / write-back / branch
// encodings, the ID/EX pipeline record and its bubble value.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    // Widths the ID/EX record is laid out with. The id_ex_pipe_reg parameters
    // default to these and must be kept equal to them.
    localparam int XLEN  = 32;
    localparam int RA_W  = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LT   = 3'd3,
        BR_GE   = 3'd4,
        BR_LTU  = 3'd5,
        BR_GEU  = 3'd6,
        BR_JUMP = 3'd7
    } br_type_t;

    // Everything the execute stage needs from decode, in one flop bank.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   data1;
        logic [XLEN-1:0]   data2;
        logic [XLEN-1:0]   imm;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
        logic              uses_rs1;
        logic              uses_rs2;
        logic              b_sel;
        logic              a_sel;
        alu_op_t           alu_op;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
        wb_sel_t           wb_sel;
        br_type_t          br_type;
        logic              pred_taken;
    } id_ex_t;

    // A bubble is a no-op: invalid, no side effects, ADD, no branch, all
    // data/address/select fields cleared.
    localparam id_ex_t ID_EX_BUBBLE = '{
        valid:      1'b0,
        pc:         '0,
        data1:      '0,
        data2:      '0,
        imm:        '0,
        rs1:        '0,
        rs2:        '0,
        rd:         '0,
        uses_rs1:   1'b0,
        uses_rs2:   1'b0,
        b_sel:      1'b0,
        a_sel:      1'b0,
        alu_op:     ALU_ADD,
        reg_wr:     1'b0,
        mem_rd:     1'b0,
        mem_wr:     1'b0,
        wb_sel:     WB_ALU,
        br_type:    BR_NONE,
        pred_taken: 1'b0
    };

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector. Raises hazard_stall when the load
// sitting in EX writes a register the decode instruction reads.
// Ports:
//   ex_valid, ex_mem_rd, ex_rd      : the instruction currently in EX
//   id_valid, id_rs1, id_rs2,
//   id_uses_rs1, id_uses_rs2        : the instruction currently in ID
//   flush, ex_stall                 : suppress the stall (kill / hold pending)
//   hazard_stall                    : freeze PC and IF/ID, bubble into EX
// -----------------------------------------------------------------------------
module load_use_detect
    import riscv_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic              ex_mem_rd,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              hazard_stall
);

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never produces a
    // value anyone can wait for.
    assign ex_is_load = ex_valid & ex_mem_rd & (ex_rd != '0);
    assign rs1_hit    = id_uses_rs1 & (ex_rd == id_rs1);
    assign rs2_hit    = id_uses_rs2 & (ex_rd == id_rs2);

    // A flush kills the decode instruction, so it must not freeze fetch; a
    // downstream hold already keeps the load in EX, so no bubble is needed.
    assign hazard_stall = ex_is_load & id_valid & (rs1_hit | rs2_hit)
                          & ~flush & ~ex_stall;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
// ID/EX pipeline register of the RV32I five-stage core. Captures decode
// operands, immediate, register addresses and control; owns load-use hazard
// detection, bubble insertion, downstream stall hold and mispredict flush.
//
// Update priority per rising edge: rst (async) > flush > ex_stall (hold)
//   > hazard_stall (bubble) > normal load.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   id_*                : decode-stage fields (valid, pc, data, imm, regs,
//                         source-use flags, selects, alu_op, controls,
//                         wb_sel, br_type, pred_taken)
//   ex_stall            : hold contents
//   flush               : branch mispredict, load a bubble
//   ex_*                : registered copies of the id_* fields
//   hazard_stall        : combinational load-use stall to PC and IF/ID
//   perf_bubble_cnt     : hazard bubbles inserted
//   perf_flush_cnt      : flushes taken
//
// Configuration macro: ID_EX_PERF_CNT_EN
//   defined   : both performance counters are implemented (wrap mod 2^32)
//   undefined : counter ports are present and tied to zero
// -----------------------------------------------------------------------------
module id_ex_pipe_reg
    import riscv_pkg::*;
#(
    parameter int size   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    input  logic [size-1:0]   id_pc,
    input  logic [size-1:0]   id_data1,
    input  logic [size-1:0]   id_data2,
    input  logic [size-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_B_Sel,
    input  logic              id_A_Sel,
    input  logic [3:0]        id_alu_op,
    input  logic              id_reg_wr,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic [1:0]        id_wb_sel,
    input  logic [2:0]        id_br_type,
    input  logic              id_pred_taken,

    input  logic              ex_stall,
    input  logic              flush,

    output logic              ex_valid,
    output logic [size-1:0]   ex_pc,
    output logic [size-1:0]   ex_data1,
    output logic [size-1:0]   ex_data2,
    output logic [size-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_uses_rs1,
    output logic              ex_uses_rs2,
    output logic              ex_B_Sel,
    output logic              ex_A_Sel,
    output logic [3:0]        ex_alu_op,
    output logic              ex_reg_wr,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic [1:0]        ex_wb_sel,
    output logic [2:0]        ex_br_type,
    output logic              ex_pred_taken,

    output logic              hazard_stall,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_flush_cnt
);

    id_ex_t stage_q;
    id_ex_t stage_d;
    id_ex_t id_fields;

    // ------------------------------------------------------------------
    // Pack the decode fields into the pipeline record.
    // ------------------------------------------------------------------
    always_comb begin
        id_fields            = ID_EX_BUBBLE;
        id_fields.valid      = id_valid;
        id_fields.pc         = id_pc;
        id_fields.data1      = id_data1;
        id_fields.data2      = id_data2;
        id_fields.imm        = id_imm;
        id_fields.rs1        = id_rs1;
        id_fields.rs2        = id_rs2;
        id_fields.rd         = id_rd;
        id_fields.uses_rs1   = id_uses_rs1;
        id_fields.uses_rs2   = id_uses_rs2;
        id_fields.b_sel      = id_B_Sel;
        id_fields.a_sel      = id_A_Sel;
        id_fields.alu_op     = alu_op_t'(id_alu_op);
        id_fields.reg_wr     = id_reg_wr;
        id_fields.mem_rd     = id_mem_rd;
        id_fields.mem_wr     = id_mem_wr;
        id_fields.wb_sel     = wb_sel_t'(id_wb_sel);
        id_fields.br_type    = br_type_t'(id_br_type);
        id_fields.pred_taken = id_pred_taken;
    end

    // ------------------------------------------------------------------
    // Load-use detection looks at what EX holds now and what ID offers.
    // ------------------------------------------------------------------
    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_valid     (stage_q.valid),
        .ex_mem_rd    (stage_q.mem_rd),
        .ex_rd        (stage_q.rd),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .flush        (flush),
        .ex_stall     (ex_stall),
        .hazard_stall (hazard_stall)
    );

    // ------------------------------------------------------------------
    // Next-state selection.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns stage_d and no latch
        // is inferred.
        stage_d = id_fields;
        if (flush) begin
            stage_d = ID_EX_BUBBLE;
        end else if (ex_stall) begin
            stage_d = stage_q;
        end else if (hazard_stall) begin
            stage_d = ID_EX_BUBBLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= ID_EX_BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign ex_valid      = stage_q.valid;
    assign ex_pc         = stage_q.pc;
    assign ex_data1      = stage_q.data1;
    assign ex_data2      = stage_q.data2;
    assign ex_imm        = stage_q.imm;
    assign ex_rs1        = stage_q.rs1;
    assign ex_rs2        = stage_q.rs2;
    assign ex_rd         = stage_q.rd;
    assign ex_uses_rs1   = stage_q.uses_rs1;
    assign ex_uses_rs2   = stage_q.uses_rs2;
    assign ex_B_Sel      = stage_q.b_sel;
    assign ex_A_Sel      = stage_q.a_sel;
    assign ex_alu_op     = stage_q.alu_op;
    assign ex_reg_wr     = stage_q.reg_wr;
    assign ex_mem_rd     = stage_q.mem_rd;
    assign ex_mem_wr     = stage_q.mem_wr;
    assign ex_wb_sel     = stage_q.wb_sel;
    assign ex_br_type    = stage_q.br_type;
    assign ex_pred_taken = stage_q.pred_taken;

    // ------------------------------------------------------------------
    // Performance counters.
    // ------------------------------------------------------------------
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;

    // hazard_stall is already gated off by flush and ex_stall, so it is
    // high exactly on edges that load a hazard bubble; a flush+hazard
    // cycle therefore counts only as a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (hazard_stall) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;
`else
    assign perf_bubble_cnt = '0;
    assign perf_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe_reg
// Self-checking bench for id_ex_pipe_reg: directed load-use / flush / hold /
// reset scenarios followed by randomized traffic, all compared against a
// behavioural model of the stage contents and performance counters.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        id_valid;
    logic [31:0] id_pc, id_data1, id_data2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2, id_B_Sel, id_A_Sel;
    logic [3:0]  id_alu_op;
    logic        id_reg_wr, id_mem_rd, id_mem_wr;
    logic [1:0]  id_wb_sel;
    logic [2:0]  id_br_type;
    logic        id_pred_taken;
    logic        ex_stall, flush;

    logic        ex_valid;
    logic [31:0] ex_pc, ex_data1, ex_data2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_uses_rs1, ex_uses_rs2, ex_B_Sel, ex_A_Sel;
    logic [3:0]  ex_alu_op;
    logic        ex_reg_wr, ex_mem_rd, ex_mem_wr;
    logic [1:0]  ex_wb_sel;
    logic [2:0]  ex_br_type;
    logic        ex_pred_taken;
    logic        hazard_stall;
    logic [31:0] perf_bubble_cnt, perf_flush_cnt;

    id_ex_pipe_reg #(.size(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_data1(id_data1),
        .id_data2(id_data2), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_B_Sel(id_B_Sel), .id_A_Sel(id_A_Sel),
        .id_alu_op(id_alu_op), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
        .id_mem_wr(id_mem_wr), .id_wb_sel(id_wb_sel), .id_br_type(id_br_type),
        .id_pred_taken(id_pred_taken),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_data1(ex_data1),
        .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_uses_rs1(ex_uses_rs1),
        .ex_uses_rs2(ex_uses_rs2), .ex_B_Sel(ex_B_Sel), .ex_A_Sel(ex_A_Sel),
        .ex_alu_op(ex_alu_op), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .ex_wb_sel(ex_wb_sel), .ex_br_type(ex_br_type),
        .ex_pred_taken(ex_pred_taken),
        .hazard_stall(hazard_stall),
        .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    // Flat view of one instruction slot; a bubble is simply all zeros.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, bsel, asel;
        logic [3:0]  alu;
        logic        rw, mr, mw;
        logic [1:0]  wb;
        logic [2:0]  br;
        logic        pt;
    } slot_t;

    slot_t dut_s, id_s, m, saved;
    int unsigned m_bub, m_fl;
    int checks = 0;
    int errors = 0;

    assign dut_s = {ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs1, ex_rs2,
                    ex_rd, ex_uses_rs1, ex_uses_rs2, ex_B_Sel, ex_A_Sel,
                    ex_alu_op, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_wb_sel,
                    ex_br_type, ex_pred_taken};
    assign id_s  = {id_valid, id_pc, id_data1, id_data2, id_imm, id_rs1, id_rs2,
                    id_rd, id_uses_rs1, id_uses_rs2, id_B_Sel, id_A_Sel,
                    id_alu_op, id_reg_wr, id_mem_rd, id_mem_wr, id_wb_sel,
                    id_br_type, id_pred_taken};

    task automatic check(input string tag, input logic [191:0] obs,
                         input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counter value visible at the ports for a given event count.
    function automatic logic [31:0] exp_cnt(input int unsigned c);
`ifdef ID_EX_PERF_CNT_EN
        return 32'(c);
`else
        return 32'(c & 0);
`endif
    endfunction

    // A load still in EX that writes a nonzero register read by a valid ID
    // instruction needs one bubble, unless a flush or hold is in progress.
    function automatic logic model_hz();
        logic reads;
        reads = (id_uses_rs1 && m.rd == id_rs1) || (id_uses_rs2 && m.rd == id_rs2);
        return !flush && !ex_stall && m.valid && m.mr && (m.rd != 5'd0)
               && id_valid && reads;
    endfunction

    task automatic clear_id();
        id_valid = 0; id_pc = 0; id_data1 = 0; id_data2 = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_B_Sel = 0; id_A_Sel = 0; id_alu_op = 0; id_reg_wr = 0;
        id_mem_rd = 0; id_mem_wr = 0; id_wb_sel = 0; id_br_type = 0;
        id_pred_taken = 0; flush = 0; ex_stall = 0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        clear_id();
        id_valid = 1; id_mem_rd = 1; id_reg_wr = 1; id_wb_sel = 2'd1;
        id_rd = rd; id_rs1 = 5'd2; id_uses_rs1 = 1; id_imm = 32'd4;
        id_pc = 32'h0000_0040 + {27'd0, rd};
    endtask

    task automatic rand_id();
        id_valid      = ($urandom_range(0, 9) != 0);
        id_pc         = $urandom;
        id_data1      = $urandom;
        id_data2      = $urandom;
        id_imm        = $urandom;
        id_rs1        = 5'($urandom_range(0, 7));
        id_rs2        = 5'($urandom_range(0, 7));
        id_rd         = 5'($urandom_range(0, 7));
        id_uses_rs1   = 1'($urandom_range(0, 1));
        id_uses_rs2   = 1'($urandom_range(0, 1));
        id_B_Sel      = 1'($urandom_range(0, 1));
        id_A_Sel      = 1'($urandom_range(0, 1));
        id_alu_op     = 4'($urandom_range(0, 15));
        id_reg_wr     = 1'($urandom_range(0, 1));
        id_mem_rd     = 1'($urandom_range(0, 1));
        id_mem_wr     = 1'($urandom_range(0, 1));
        id_wb_sel     = 2'($urandom_range(0, 3));
        id_br_type    = 3'($urandom_range(0, 7));
        id_pred_taken = 1'($urandom_range(0, 1));
    endtask

    // One clock: inputs are set (after a negedge); check the combinational
    // stall, step the model across the edge, then check the registered view.
    task automatic cyc();
        logic  hz;
        slot_t nxt;
        #1;
        hz = model_hz();
        check("hazard_stall", 192'(hazard_stall), 192'(hz));
        if (flush) begin
            nxt = '0;
            m_fl++;
        end else if (ex_stall) begin
            nxt = m;
        end else if (hz) begin
            nxt = '0;
            m_bub++;
        end else begin
            nxt = id_s;
        end
        @(posedge clk);
        #1;
        m = nxt;
        check("ex_fields", 192'(dut_s), 192'(m));
        check("perf_bubble_cnt", 192'(perf_bubble_cnt), 192'(exp_cnt(m_bub)));
        check("perf_flush_cnt", 192'(perf_flush_cnt), 192'(exp_cnt(m_fl)));
        @(negedge clk);
    endtask

    initial begin
        clear_id();
        rst = 1;
        m = '0; m_bub = 0; m_fl = 0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ex", 192'(dut_s), 192'(0));
        check("reset_bub", 192'(perf_bubble_cnt), 192'(0));
        check("reset_flush", 192'(perf_flush_cnt), 192'(0));
        rst = 0;

        // Normal flow: immediate steered to operand B.
        clear_id();
        id_valid = 1; id_pc = 32'h100; id_data2 = 32'h1234;
        id_imm = 32'hFFFF_FFF0; id_B_Sel = 1; id_reg_wr = 1; id_rd = 5'd3;
        cyc();
        check("flow_imm", 192'(ex_imm), 192'(32'hFFFF_FFF0));
        check("flow_bsel", 192'(ex_B_Sel), 192'(1));
        check("flow_valid", 192'(ex_valid), 192'(1));
        check("flow_data2", 192'(ex_data2), 192'(32'h1234));

        // Load-use: lw x5 then add x6,x5,x7.
        set_load(5'd5);
        cyc();
        clear_id();
        id_valid = 1; id_pc = 32'h108; id_rs1 = 5'd5; id_uses_rs1 = 1;
        id_rs2 = 5'd7; id_uses_rs2 = 1; id_rd = 5'd6; id_reg_wr = 1;
        #1;
        check("lu_stall", 192'(hazard_stall), 192'(1));
        cyc();
        check("lu_bubble_valid", 192'(ex_valid), 192'(0));
        check("lu_bubble_memrd", 192'(ex_mem_rd), 192'(0));
        #1;
        check("lu_release", 192'(hazard_stall), 192'(0));
        cyc();
        check("lu_add_rd", 192'(ex_rd), 192'(6));
        check("lu_add_valid", 192'(ex_valid), 192'(1));
        check("lu_bub_cnt", 192'(perf_bubble_cnt), 192'(exp_cnt(1)));

        // x0 destination never stalls.
        set_load(5'd0);
        cyc();
        clear_id();
        id_valid = 1; id_rs1 = 5'd0; id_uses_rs1 = 1; id_uses_rs2 = 1;
        #1;
        check("x0_no_stall", 192'(hazard_stall), 192'(0));
        cyc();

        // Unused rs2 matching the load destination never stalls.
        set_load(5'd5);
        cyc();
        clear_id();
        id_valid = 1; id_rs1 = 5'd3; id_uses_rs1 = 1;
        id_rs2 = 5'd5; id_uses_rs2 = 0;
        #1;
        check("unused_rs2", 192'(hazard_stall), 192'(0));
        cyc();

        // Flush + hold + load-use together: flush wins, counts as flush only.
        set_load(5'd5);
        cyc();
        clear_id();
        id_valid = 1; id_rs1 = 5'd5; id_uses_rs1 = 1; id_rd = 5'd9;
        flush = 1; ex_stall = 1;
        #1;
        check("simul_stall", 192'(hazard_stall), 192'(0));
        cyc();
        check("simul_bubble", 192'(dut_s), 192'(0));
        check("simul_flush_cnt", 192'(perf_flush_cnt), 192'(exp_cnt(1)));
        check("simul_bub_cnt", 192'(perf_bubble_cnt), 192'(exp_cnt(1)));

        // Hold for three cycles while decode changes underneath.
        clear_id();
        id_valid = 1; id_pc = 32'h200; id_data1 = 32'hCAFE_0001;
        id_rd = 5'd4; id_reg_wr = 1; id_alu_op = 4'd5;
        cyc();
        saved = m;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            flush = 0; ex_stall = 1;
            cyc();
            check("hold_fields", 192'(dut_s), 192'(saved));
            check("hold_bub_cnt", 192'(perf_bubble_cnt), 192'(exp_cnt(1)));
            check("hold_flush_cnt", 192'(perf_flush_cnt), 192'(exp_cnt(1)));
        end

        // Asynchronous reset in the middle of a cycle with valid contents.
        set_load(5'd7);
        cyc();
        rand_id();
        ex_stall = 1;
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        check("async_rst_ex", 192'(dut_s), 192'(0));
        check("async_rst_bub", 192'(perf_bubble_cnt), 192'(0));
        check("async_rst_flush", 192'(perf_flush_cnt), 192'(0));
        m = '0; m_bub = 0; m_fl = 0;
        @(negedge clk);
        rst = 0;
        clear_id();
        id_valid = 1; id_pc = 32'h300; id_rd = 5'd1; id_reg_wr = 1;
        cyc();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rand_id();
            flush    = ($urandom_range(0, 9) == 0);
            ex_stall = ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register for the RV32I five-stage core. It captures decoded operands, immediate, register addresses and control from decode. It presents them to the execute stage, where B_Sel steers the ALU operand-B mux between `ex_data2` and `ex_imm`. It owns load-use hazard detection, bubble insertion, downstream stall hold and branch-mispredict flush.

## Interface
Parameters:
- `size`, 32: datapath width.
- `REG_AW`, 5: register-address width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_pc` in `size`: PC of the decode instruction.
- `id_data1`, `id_data2`, `id_imm` in `size` each: register-file reads and the sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd` in `REG_AW` each: register addresses.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: the instruction reads that source.
- `id_B_Sel`, `id_A_Sel` in 1 each: operand selects.
- `id_alu_op` in 4: ALU operation.
- `id_reg_wr`, `id_mem_rd`, `id_mem_wr` in 1 each: write-back and memory controls.
- `id_wb_sel` in 2: write-back source select.
- `id_br_type` in 3: branch type.
- `id_pred_taken` in 1: YAGS prediction for this instruction.
- `ex_stall` in 1: execute or later stage is stalled; hold contents.
- `flush` in 1: branch mispredict; kill the contents.
- `ex_*` out, widths matching their `id_*` sources: registered copies. Includes `ex_valid`, `ex_B_Sel` and `ex_pred_taken`.
- `hazard_stall` out 1: combinational; freezes PC and IF/ID.
- `perf_bubble_cnt`, `perf_flush_cnt` out 32 each: performance counters.

## Operation
- Every rising edge updates the register by the first matching rule, highest priority first:
  - `rst` (async): all outputs 0.
  - `flush`: load a bubble.
  - `ex_stall`: hold all fields.
  - `hazard_stall`: load a bubble.
  - Otherwise: load all `id_*` fields.
- A bubble sets:
  - `ex_valid` = 0.
  - `ex_reg_wr`, `ex_mem_rd`, `ex_mem_wr`, `ex_pred_taken` = 0.
  - `ex_br_type` = 0 (none), `ex_alu_op` = 0 (ADD).
  - Data, address and select fields = 0.
- `hazard_stall` = `ex_valid` & `ex_mem_rd` & (`ex_rd` != 0) & `id_valid` & (hit on rs1 or rs2).
  - rs1 hit: `id_uses_rs1` & (`ex_rd` == `id_rs1`).
  - rs2 hit: `id_uses_rs2` & (`ex_rd` == `id_rs2`).
- `hazard_stall` is forced to 0 while `flush` = 1. The killed decode instruction must not freeze fetch.
- `hazard_stall` is also forced to 0 while `ex_stall` = 1. The hold already prevents the load from advancing.
- `x0` never causes a hazard.
- A bubble with `id_valid` = 0 is indistinguishable from a normal load of an invalid slot.

## Timing
- Latency: one cycle from `id_*` to `ex_*`.
- `hazard_stall` has zero latency and depends only on current `ex_*` and `id_*`.
- Load-use costs exactly one bubble:
  - Cycle N: `hazard_stall` = 1, and the bubble is loaded at the edge.
  - Cycle N+1: `ex_mem_rd` = 0, so `hazard_stall` = 0 and the consumer loads normally.
- `flush` and `ex_stall` both high: flush wins, and the bubble is loaded.
- Reset is asserted asynchronously and released synchronously by the upstream reset synchroniser. The first edge after release performs a normal load.
- Reset mid-stall or mid-bubble: all state clears immediately, and the counters clear as well.

## Configuration
- `ID_EX_PERF_CNT_EN` defined:
  - `perf_bubble_cnt` increments on every edge where a hazard bubble is loaded.
  - `perf_flush_cnt` increments on every edge where flush is taken.
  - Both counters wrap modulo 2^32 and reset to 0.
  - A cycle with both `flush` and `hazard_stall` high counts only as a flush. `hazard_stall` is forced low in that cycle.
- Undefined: both ports are still present and tied to 0, and no counter flops are instantiated.

## Structure
- Shared package `riscv_pkg` holds:
  - `alu_op_t`, `wb_sel_t` and `br_type_t` enums.
  - `ALU_ADD` and `BR_NONE` constants.
  - `id_ex_t` packed struct of all registered fields.
  - `ID_EX_BUBBLE` constant.
- The register is a single `id_ex_t` flop bank.
- One sub-module, `load_use_detect`, is purely combinational and produces `hazard_stall`.

## Test plan
- Reset during a valid load: assert `rst` mid-cycle. All `ex_*` = 0 immediately, and both counters = 0.
- Normal flow: `id_data2` = 0x1234, `id_imm` = 0xFFFFFFF0, `id_B_Sel` = 1. Next cycle `ex_imm` = 0xFFFFFFF0, `ex_B_Sel` = 1, `ex_valid` = 1.
- Load-use: EX holds `lw x5` (`ex_rd` = 5, `ex_mem_rd` = 1); ID holds `add x6,x5,x7` (`id_rs1` = 5, `id_uses_rs1` = 1).
  - `hazard_stall` = 1 for one cycle, then a bubble is loaded.
  - The add loads on the following edge, and `perf_bubble_cnt` = 1 with the macro defined.
- x0 and unused-source cases, each with EX holding a load:
  - `ex_rd` = 0 with `id_rs1` = 0: `hazard_stall` = 0.
  - `id_rs2` = 5 with `id_uses_rs2` = 0 (I-type): `hazard_stall` = 0.
- Simultaneous events: `flush` = 1, `ex_stall` = 1, and a load-use condition present.
  - Result: bubble loaded, `hazard_stall` = 0, `perf_flush_cnt` = 1, `perf_bubble_cnt` unchanged.
- Hold: `ex_stall` = 1 for 3 cycles while the `id_*` inputs change. `ex_*` stays at its pre-stall values, and no counter moves.
